// File: rtl/dcache_store_buffer.sv
// Coalescing store buffer: absorbs word stores, merges same-word stores, forwards bytes to loads, drains one write at a time.
// Latency: accepted push visible in count next cycle; wr_valid two cycles after push into an empty buffer.
// Backpressure: push_ready drops when full unless the store merges; drain holds wr_valid until wr_ready, then waits for wr_bvalid.
module dcache_store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [DATA_W/8-1:0]   push_wstrb,
    input  logic [DATA_W-1:0]     push_wdata,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W/8-1:0]   ld_bytes,
    output logic                  fwd_hit,
    output logic                  fwd_stall,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  wr_bvalid,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B} state_t;

    logic [WA_W-1:0]   addr_q [DEPTH];
    logic [WA_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [NB-1:0]     strb_q [DEPTH];
    logic [NB-1:0]     strb_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    state_t            state_q, state_d;

    logic [WA_W-1:0]   push_wa, ld_wa;
    logic [PTR_W-1:0]  youngest;
    logic [PTR_W-1:0]  age_idx [DEPTH];
    logic              merge_cond, push_fire, do_merge, do_alloc, do_pop;
    logic [NB-1:0]     push_mask_covered, covered_raw, covered;
    logic [DATA_W-1:0] fwd_dat;
    logic              unused_addr_lsbs;

    assign push_wa  = push_addr[ADDR_W-1:OFF_W];
    assign ld_wa    = ld_addr[ADDR_W-1:OFF_W];
    assign youngest = tail_q - PTR_W'(1);
    assign unused_addr_lsbs = ^{push_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

    // The head becomes immutable once the drain FSM has started on it.
    assign merge_cond = (count_q != '0) && vld_q[youngest] &&
                        (addr_q[youngest] == push_wa) &&
                        !((youngest == head_q) && (state_q != IDLE));

    assign push_ready = !full_q || merge_cond;
    assign push_fire  = push_valid && push_ready;
    assign do_merge   = push_fire && merge_cond;
    assign do_alloc   = push_fire && !merge_cond;
    assign do_pop     = (state_q == WAIT_B) && wr_bvalid;

    always_comb begin
        push_mask_covered = push_wstrb;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;

        if (do_merge) begin
            for (int b = 0; b < NB; b++) begin
                if (push_wstrb[b]) begin
                    data_d[youngest][b*8 +: 8] = push_wdata[b*8 +: 8];
                end
            end
            strb_d[youngest] = strb_q[youngest] | push_wstrb;
        end

        if (do_alloc) begin
            addr_d[tail_q] = push_wa;
            for (int b = 0; b < NB; b++) begin
                data_d[tail_q][b*8 +: 8] = push_mask_covered[b] ? push_wdata[b*8 +: 8] : 8'h00;
            end
            strb_d[tail_q] = push_wstrb;
            vld_d[tail_q]  = 1'b1;
            tail_d         = tail_q + PTR_W'(1);
        end

        if (do_pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end

        case (state_q)
            IDLE:    if (!empty_q)  state_d = ISSUE;
            ISSUE:   if (wr_ready)  state_d = WAIT_B;
            WAIT_B:  if (wr_bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Walk oldest to youngest so younger matching bytes override older ones.
    always_comb begin
        fwd_dat     = '0;
        covered_raw = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k] = head_q + PTR_W'(k);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[age_idx[k]] && (addr_q[age_idx[k]] == ld_wa)) begin
                for (int b = 0; b < NB; b++) begin
                    if (strb_q[age_idx[k]][b]) begin
                        fwd_dat[b*8 +: 8] = data_q[age_idx[k]][b*8 +: 8];
                        covered_raw[b]    = 1'b1;
                    end
                end
            end
        end
        covered = covered_raw & ld_bytes;
    end

    assign fwd_data  = fwd_dat;
    assign fwd_hit   = (ld_bytes != '0) && (covered == ld_bytes);
    assign fwd_stall = (covered != '0) && (covered != ld_bytes);

    assign wr_valid = (state_q == ISSUE);
    assign wr_addr  = {addr_q[head_q], {OFF_W{1'b0}}};
    assign wr_data  = data_q[head_q];
    assign wr_strb  = strb_q[head_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            state_q <= IDLE;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench for dcache_store_buffer: push/drain latency, merging, full handling, forwarding and reset mid-drain.
module tb_dcache_store_buffer;
    logic        clk;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_addr;
    logic [3:0]  push_wstrb;
    logic [31:0] push_wdata;
    logic [31:0] ld_addr;
    logic [3:0]  ld_bytes;
    logic        fwd_hit;
    logic        fwd_stall;
    logic [31:0] fwd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_bvalid;
    logic        empty;
    logic        full;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    dcache_store_buffer dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_wstrb(push_wstrb), .push_wdata(push_wdata),
        .ld_addr(ld_addr), .ld_bytes(ld_bytes),
        .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_bvalid(wr_bvalid),
        .empty(empty), .full(full), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_one();
        int n = 0;
        while (wr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (wr_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_timeout: wr_valid=%b required 1", wr_valid);
        end
        wr_ready = 1'b1;
        step();
        wr_ready  = 1'b0;
        wr_bvalid = 1'b1;
        step();
        wr_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push_valid = 0; push_addr = 0; push_wstrb = 0; push_wdata = 0;
        ld_addr = 0; ld_bytes = 0; wr_ready = 0; wr_bvalid = 0;
        #3 rst = 1'b0;
        #1;
        total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty: got %b required 1", empty); end
        total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full: got %b required 0", full); end
        total++; if (count !== 4'd0)      begin bad++; $display("FAIL reset_count: got %0d required 0", count); end
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready: got %b required 1", push_ready); end
        total++; if (wr_valid !== 1'b0)   begin bad++; $display("FAIL reset_wr_valid: got %b required 0", wr_valid); end
        total++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL reset_fwd: hit=%b stall=%b required 0 0", fwd_hit, fwd_stall); end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_drain();
        wr_ready = 1'b1;
        push_valid = 1; push_addr = 32'h100; push_wstrb = 4'hF; push_wdata = 32'hAABBCCDD;
        step();
        push_valid = 0;
        #1;
        total++; if (count !== 4'd1)    begin bad++; $display("FAIL basic_count_n1: got %0d required 1", count); end
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL basic_wr_valid_n1: got %b required 0", wr_valid); end
        step();
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL basic_wr_valid_n2: got %b required 1", wr_valid); end
        total++; if (wr_addr !== 32'h100 || wr_data !== 32'hAABBCCDD || wr_strb !== 4'hF)
            begin bad++; $display("FAIL basic_payload: got %h/%h/%h required 00000100/aabbccdd/f", wr_addr, wr_data, wr_strb); end
        step();
        wr_ready = 1'b0;
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_b: wr_valid=%b required 0", wr_valid); end
        wr_bvalid = 1'b1;
        step();
        wr_bvalid = 1'b0;
        total++; if (empty !== 1'b1 || count !== 4'd0)
            begin bad++; $display("FAIL basic_empty_after_resp: empty=%b count=%0d required 1 0", empty, count); end
    endtask

    task automatic test_merge();
        wr_ready = 1'b0;
        push_valid = 1; push_addr = 32'h200; push_wstrb = 4'h1; push_wdata = 32'h11;
        step();
        push_addr = 32'h202; push_wstrb = 4'h4; push_wdata = 32'h00330000;
        #1;
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL merge_ready: got %b required 1", push_ready); end
        step();
        push_valid = 0;
        #1;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL merge_count: got %0d required 1", count); end
        total++; if (wr_valid !== 1'b1 || wr_strb !== 4'h5 || wr_data !== 32'h00330011)
            begin bad++; $display("FAIL merge_payload: valid=%b strb=%h data=%h required 1 5 00330011", wr_valid, wr_strb, wr_data); end
        push_valid = 1; push_addr = 32'h200; push_wstrb = 4'h2; push_wdata = 32'h2200;
        step();
        push_valid = 0;
        #1;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL merge_locked_alloc: count=%0d required 2", count); end
        drain_one();
        drain_one();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL merge_drained: count=%0d required 0", count); end
    endtask

    task automatic test_full();
        wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_valid = 1; push_addr = 32'h500 + 32'(4 * i); push_wstrb = 4'hF; push_wdata = 32'(i);
            step();
        end
        push_valid = 0;
        #1;
        total++; if (full !== 1'b1 || count !== 4'd8)
            begin bad++; $display("FAIL full_flag: full=%b count=%0d required 1 8", full, count); end
        push_valid = 1; push_addr = 32'h600; push_wstrb = 4'hF; push_wdata = 32'hDEAD;
        #1;
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_stall_ready: got %b required 0", push_ready); end
        step();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_stall_count: got %0d required 8", count); end
        push_addr = 32'h51C; push_wstrb = 4'h1; push_wdata = 32'hEE;
        #1;
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL full_merge_ready: got %b required 1", push_ready); end
        step();
        push_valid = 0;
        ld_addr = 32'h51C; ld_bytes = 4'hF;
        #1;
        total++; if (count !== 4'd8 || full !== 1'b1)
            begin bad++; $display("FAIL full_merge_count: count=%0d full=%b required 8 1", count, full); end
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h000000EE)
            begin bad++; $display("FAIL full_merge_fwd: hit=%b data=%h required 1 000000ee", fwd_hit, fwd_data); end
        ld_bytes = 4'h0;
        for (int i = 0; i < 8; i++) drain_one();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained: empty=%b required 1", empty); end
    endtask

    task automatic test_forward();
        wr_ready = 1'b0;
        push_valid = 1; push_addr = 32'h300; push_wstrb = 4'hF; push_wdata = 32'h11223344;
        step();
        push_valid = 0;
        step();
        push_valid = 1; push_addr = 32'h300; push_wstrb = 4'h3; push_wdata = 32'h5566;
        step();
        push_valid = 0;
        ld_addr = 32'h300; ld_bytes = 4'hF;
        #1;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL fwd_locked_count: got %0d required 2", count); end
        total++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'h11225566)
            begin bad++; $display("FAIL fwd_youngest: hit=%b stall=%b data=%h required 1 0 11225566", fwd_hit, fwd_stall, fwd_data); end
        total++; if (wr_data !== 32'h11223344)
            begin bad++; $display("FAIL fwd_head_payload: got %h required 11223344", wr_data); end
        ld_addr = 32'h304;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 32'h0)
            begin bad++; $display("FAIL fwd_miss: hit=%b stall=%b data=%h required 0 0 0", fwd_hit, fwd_stall, fwd_data); end
        push_valid = 1; push_addr = 32'h304; push_wstrb = 4'hF; push_wdata = 32'h99;
        #1;
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_same_cycle_push: hit=%b required 0", fwd_hit); end
        push_valid = 0;
        ld_bytes = 4'h0;
        drain_one();
        drain_one();
    endtask

    task automatic test_partial();
        push_valid = 1; push_addr = 32'h400; push_wstrb = 4'h3; push_wdata = 32'hBEEF;
        step();
        push_valid = 0;
        ld_addr = 32'h400; ld_bytes = 4'hF;
        #1;
        total++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== 32'h0000BEEF)
            begin bad++; $display("FAIL partial_stall: stall=%b hit=%b data=%h required 1 0 0000beef", fwd_stall, fwd_hit, fwd_data); end
        ld_bytes = 4'h3;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL partial_subset_hit: hit=%b stall=%b required 1 0", fwd_hit, fwd_stall); end
        ld_bytes = 4'h0;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL partial_no_bytes: hit=%b stall=%b required 0 0", fwd_hit, fwd_stall); end
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        wr_ready = 1'b0;
        while (wr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL rstmid_issue_timeout: wr_valid=%b required 1", wr_valid); end
        #2 rst = 1'b0;
        #1;
        total++; if (wr_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1)
            begin bad++; $display("FAIL rstmid_immediate: wr_valid=%b count=%0d empty=%b required 0 0 1", wr_valid, count, empty); end
        step();
        rst = 1'b1;
        wr_bvalid = 1'b1;
        step();
        step();
        wr_bvalid = 1'b0;
        ld_addr = 32'h400; ld_bytes = 4'h3;
        #1;
        total++; if (count !== 4'd0 || wr_valid !== 1'b0 || empty !== 1'b1)
            begin bad++; $display("FAIL rstmid_late_bvalid: count=%0d wr_valid=%b empty=%b required 0 0 1", count, wr_valid, empty); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL rstmid_fwd_cleared: hit=%b required 0", fwd_hit); end
        ld_bytes = 4'h0;
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_merge();
        test_full();
        test_forward();
        test_partial();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_store_buffer.md
Name: dcache_store_buffer

Overview:
- Parametrised, coalescing store buffer between the dcache store path and the AXI write channel.
- Absorbs committed word stores, merges back-to-back stores to the same word, and forwards buffered bytes to loads.
- Drains to memory one write at a time, in order.
- The uncache path and CACOP path wait on `empty` for ordering.

Parameters:
- ADDR_W, 32, physical address width
- DATA_W, 32, store data width; `DATA_W/8` byte lanes
- DEPTH, 8, entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of the `count` output

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- push_valid  input  1  store request
- push_ready  output  1  buffer can accept the store
- push_addr  input  ADDR_W  store address; low $clog2(DATA_W/8) bits ignored
- push_wstrb  input  DATA_W/8  byte enables
- push_wdata  input  DATA_W  store data
- ld_addr  input  ADDR_W  load lookup address
- ld_bytes  input  DATA_W/8  bytes the load needs
- fwd_hit  output  1  all requested bytes are buffered
- fwd_stall  output  1  some, but not all, requested bytes are buffered
- fwd_data  output  DATA_W  forwarded data; youngest byte wins
- wr_valid  output  1  AXI write request
- wr_ready  input  1  AXI write accepted
- wr_addr  output  ADDR_W  word-aligned write address
- wr_data  output  DATA_W  write data
- wr_strb  output  DATA_W/8  write strobes
- wr_bvalid  input  1  write response
- empty  output  1  no entries
- full  output  1  count == DEPTH
- count  output  CNT_W  valid entries

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; head and tail pointers = 0; count = 0.
  - Drain FSM = IDLE.
  - Outputs: empty=1, full=0, push_ready=1, wr_valid=0, fwd_hit=0, fwd_stall=0.
- Storage:
  - Circular FIFO with head (oldest) and tail (next free) pointers; pointers wrap modulo DEPTH.
  - Each entry holds a word address, DATA_W of data and a byte strobe.
- Merge:
  - Condition: count>0, push word address equals the youngest entry's address, and the youngest entry is not locked.
  - An entry is locked when it is the head and the FSM is not in IDLE.
  - On an accepted merging push: data is overwritten only for set push_wstrb bytes; strobe |= push_wstrb; count is unchanged.
- Allocation: an accepted non-merging push writes entry[tail], tail++, count++.
- push_ready = !full || merge-condition.
- Push while full with no merge: push_ready=0. A pop in the same cycle does not raise push_ready; ready depends only on registered state.
- Simultaneous allocate and pop: count unchanged; both pointers advance.
- Drain FSM:
  - IDLE: if !empty, go to ISSUE. wr_bvalid is ignored.
  - ISSUE: wr_valid=1; wr_addr/wr_data/wr_strb are driven combinationally from entry[head]. Hold until wr_ready, then go to WAIT_B. wr_bvalid is ignored.
  - WAIT_B: on wr_bvalid, invalidate head, head++, count--, go to IDLE.
  - At most one write is outstanding. There is one idle bubble between consecutive drains.
- Latency: a push accepted into an empty buffer at cycle N gives count=1 at N+1 and wr_valid=1 at N+2.
- A merge into the unlocked head in the same cycle the FSM leaves IDLE is legal. The issued payload includes the merged bytes.
- Forwarding:
  - Combinational over all valid entries, including the in-flight head until it pops.
  - A push in the current cycle is not visible to forwarding.
  - Per byte lane: the youngest entry with a matching word address and that strobe bit set supplies fwd_data.
  - Uncovered lanes drive 0.
  - covered = union of the matching strobes, restricted to ld_bytes.
  - fwd_hit = (ld_bytes != 0) && (covered == ld_bytes).
  - fwd_stall = (covered != 0) && (covered != ld_bytes).
  - Both are 0 when no entry matches.
- Reset mid-drain: wr_valid drops immediately. A later wr_bvalid in IDLE is ignored.
- `full`, `empty` and `count` are registered and reflect the state after each edge.

Test Plan:
- Reset, then push addr 0x100, strb 0xF, data 0xAABBCCDD; wr_ready=1, wr_bvalid 2 cycles later -> count=1 at N+1; wr_valid at N+2 with wr_addr 0x100, wr_data 0xAABBCCDD, wr_strb 0xF; empty=1 after the response.
- Hold wr_ready=0; push 0x200 strb 0x1 data 0x11, then 0x202 strb 0x4 data 0x00330000 -> single entry count=1 with strb 0x5 and data 0x00330011. Next push to 0x200 after the FSM reaches ISSUE -> new entry, count=2.
- Hold wr_ready=0; push 8 distinct addresses -> full=1, push_ready=0. A ninth store to a new address stalls. A store to the youngest's address is still accepted, count stays 8.
- Buffer 0x300 strb 0xF data 0x11223344, then 0x300 strb 0x3 data 0x5566 after the older entry locks. Load 0x300 with ld_bytes 0xF -> fwd_hit=1, fwd_data 0x11225566. Load 0x304 -> hit=0, stall=0.
- Buffer 0x400 strb 0x3; load with ld_bytes 0xF -> fwd_stall=1, fwd_hit=0.
- Assert rst low while wr_valid=1 -> wr_valid=0 and count=0 immediately. A later wr_bvalid=1 causes no state change.
